lifo_stack: RTL



---
 rtl/stack_defs.sv | 28 ++
 rtl/lifo_stack_mem.sv | 33 +++
 rtl/lifo_stack.sv | 135 +++++++++++++
 3 files changed

// File: rtl/stack_defs.sv
`default_nettype none
// =============================================================================
// Module      : stack_defs
// Description : Shared operation encodings and sizing helper for lifo_stack.
// Revision    : 1.0 - initial release
// =============================================================================
package stack_defs;

    // Encodings of the {push, pop} strobe pair
    localparam logic [1:0] OP_IDLE    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    // Ceiling log2; bounded so the shift never reaches the sign bit
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_stack_mem.sv
`default_nettype none
// =============================================================================
// Module      : lifo_stack_mem
// Description : DEPTH x WIDTH register array, one sync write, one async read.
// Revision    : 1.0 - initial release
// =============================================================================
module lifo_stack_mem
    import stack_defs::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// =============================================================================
// Module      : lifo_stack
// Description : Parametrised synchronous LIFO with status, peek, replace and
//               sticky overflow/underflow errors.
// Revision    : 1.0 - initial release
// =============================================================================
module lifo_stack
    import stack_defs::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear_err,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             error
);

    localparam int AW = clog2(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == CNT_W'(DEPTH));
    assign w_wr_idx = AW'(count_q);
    // Parked at 0 when empty so the read address always stays in range
    assign w_top_idx = w_empty ? '0 : AW'(count_q - CNT_W'(1));

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q & ~clear_err;
        unf_d   = unf_q & ~clear_err;
        w_we    = 1'b0;
        w_waddr = w_wr_idx;

        case ({push, pop})
            OP_PUSH: begin
                if (w_full) begin
                    ovf_d = 1'b1;
                end else begin
                    w_we    = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    unf_d = 1'b1;
                end else begin
                    dout_d  = w_rdata;
                    valid_d = 1'b1;
                    count_d = count_q - CNT_W'(1);
                end
            end
            OP_REPLACE: begin
                valid_d = 1'b1;
                if (w_empty) begin
                    dout_d = data_in;
                end else begin
                    dout_d  = w_rdata;
                    w_we    = 1'b1;
                    w_waddr = w_top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    lifo_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_we & ~reset),
        .waddr_i (w_waddr),
        .wdata_i (data_in),
        .raddr_i (w_top_idx),
        .rdata_o (w_rdata)
    );

    assign data_out  = dout_q;
    assign out_valid = valid_q;
    assign top       = w_empty ? '0 : w_rdata;
    assign count     = count_q;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign error     = ovf_q | unf_q;

endmodule
`default_nettype wire
